// File: rtl/display_pkg.sv
//----------------------------------------------------------------------------
// display_pkg
// Mode encodings, seven-segment glyph codes and digit count shared by the
// display controller and its glyph ROM.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ECHO    = 3'd1,
        ST_LOWPASS = 3'd2,
        ST_PLUS    = 3'd3,
        ST_MINUS   = 3'd4
    } mode_t;

    localparam int c_num_digits = 4;

    // Segment order {a,b,c,d,e,f,g}, active-low.
    localparam logic [6:0] c_glyph_e     = 7'b0110000;
    localparam logic [6:0] c_glyph_c     = 7'b0110001;
    localparam logic [6:0] c_glyph_h     = 7'b1001000;
    localparam logic [6:0] c_glyph_o     = 7'b0000001;
    localparam logic [6:0] c_glyph_l     = 7'b1110001;
    localparam logic [6:0] c_glyph_p     = 7'b0011000;
    localparam logic [6:0] c_glyph_u     = 7'b1000001;
    localparam logic [6:0] c_glyph_d     = 7'b1000010;
    localparam logic [6:0] c_glyph_n     = 7'b1101010;
    localparam logic [6:0] c_glyph_dash  = 7'b1111110;
    localparam logic [6:0] c_glyph_blank = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/mode_glyph_rom.sv
//----------------------------------------------------------------------------
// mode_glyph_rom
// Combinational lookup of the seven-segment glyph for a (mode, digit) pair.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module mode_glyph_rom
    import display_pkg::*;
(
    input  logic [2:0] i_mode,
    input  logic [1:0] i_digit,
    output logic [6:0] o_glyph
);

    // Digit 3 is the leftmost character of each word.
    always_comb begin
        o_glyph = c_glyph_blank;
        case (i_mode)
            ST_IDLE: o_glyph = c_glyph_dash;
            ST_ECHO: begin
                case (i_digit)
                    2'd3:    o_glyph = c_glyph_e;
                    2'd2:    o_glyph = c_glyph_c;
                    2'd1:    o_glyph = c_glyph_h;
                    default: o_glyph = c_glyph_o;
                endcase
            end
            ST_LOWPASS: begin
                if (i_digit == 2'd3)      o_glyph = c_glyph_l;
                else if (i_digit == 2'd2) o_glyph = c_glyph_p;
            end
            ST_PLUS: begin
                if (i_digit == 2'd3)      o_glyph = c_glyph_u;
                else if (i_digit == 2'd2) o_glyph = c_glyph_p;
            end
            ST_MINUS: begin
                if (i_digit == 2'd3)      o_glyph = c_glyph_d;
                else if (i_digit == 2'd2) o_glyph = c_glyph_n;
            end
            default: o_glyph = c_glyph_blank;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mode_display_ctrl.sv
//----------------------------------------------------------------------------
// mode_display_ctrl
// Priority mode selection with volume-feedback hold, driving a multiplexed
// 4-digit common-anode seven-segment display.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module mode_display_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo_en,
    input  logic       lowpass_en,
    input  logic       plus,
    input  logic       minus,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [2:0] mode
);

    localparam int c_presc_w = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_hold_w  = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(REFRESH_DIV - 1);
    localparam logic [c_hold_w-1:0]  c_hold_load  = c_hold_w'(HOLD_CYCLES);
    localparam logic [c_hold_w-1:0]  c_hold_one   = c_hold_w'(1);

    mode_t                r_state;
    logic [c_hold_w-1:0]  r_hold;
    logic                 r_plus_q;
    logic                 r_minus_q;
    logic [c_presc_w-1:0] r_presc;
    logic [1:0]           r_digit;
    logic                 r_lit;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;

    logic                 w_plus_edge;
    logic                 w_minus_edge;
    logic                 w_in_hold;
    logic [6:0]           w_glyph;

    assign w_plus_edge  = plus  & ~r_plus_q;
    assign w_minus_edge = minus & ~r_minus_q;
    // The counter includes the current cycle, so a load of HOLD_CYCLES gives
    // exactly HOLD_CYCLES cycles in the volume mode before re-evaluation.
    assign w_in_hold    = ((r_state == ST_PLUS) || (r_state == ST_MINUS)) &&
                          (r_hold > c_hold_one);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_hold    <= '0;
            r_plus_q  <= 1'b0;
            r_minus_q <= 1'b0;
        end else begin
            r_plus_q  <= plus;
            r_minus_q <= minus;
            if (w_plus_edge) begin
                r_state <= ST_PLUS;
                r_hold  <= c_hold_load;
            end else if (w_minus_edge) begin
                r_state <= ST_MINUS;
                r_hold  <= c_hold_load;
            end else if (w_in_hold) begin
                r_hold  <= r_hold - c_hold_one;
            end else if (echo_en) begin
                r_state <= ST_ECHO;
                r_hold  <= '0;
            end else if (lowpass_en) begin
                r_state <= ST_LOWPASS;
                r_hold  <= '0;
            end else begin
                r_state <= ST_IDLE;
                r_hold  <= '0;
            end
        end
    end

    mode_glyph_rom u_rom (
        .i_mode  (r_state),
        .i_digit (r_digit),
        .o_glyph (w_glyph)
    );

    // Digits stay dark until the first prescaler wrap, then anode and glyph
    // are registered together from the same index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_digit <= 2'd0;
            r_lit   <= 1'b0;
            r_an    <= 4'b1111;
            r_seg   <= c_glyph_blank;
        end else begin
            if (r_presc == c_presc_last) begin
                r_presc <= '0;
                r_digit <= r_digit + 2'd1;
                r_lit   <= 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (r_lit) begin
                r_an  <= ~(4'b0001 << r_digit);
                r_seg <= w_glyph;
            end else begin
                r_an  <= 4'b1111;
                r_seg <= c_glyph_blank;
            end
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign mode = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mode_display_ctrl.sv
//----------------------------------------------------------------------------
// tb_mode_display_ctrl
// Directed self-checking bench for mode_display_ctrl.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_mode_display_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       echo_en;
    logic       lowpass_en;
    logic       plus;
    logic       minus;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] mode;

    int n_pass  = 0;
    int n_total = 0;

    mode_display_ctrl #(
        .REFRESH_DIV (4),
        .HOLD_CYCLES (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .echo_en    (echo_en),
        .lowpass_en (lowpass_en),
        .plus       (plus),
        .minus      (minus),
        .seg        (seg),
        .an         (an),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    function automatic logic [3:0] an_of(input int d);
        case (d % 4)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    initial begin
        logic [3:0] seen;
        logic [6:0] exp_seg;
        logic       found;

        rst = 1'b1; echo_en = 1'b0; lowpass_en = 1'b0; plus = 1'b0; minus = 1'b0;
        tick(); tick(); tick();
        check("reset_seg", seg, 7'b1111111);
        check("reset_an", {3'b0, an}, 7'b0001111);
        check("reset_mode", {4'b0, mode}, 7'd0);

        // Idle scan: first digit lights 5 edges after release with index 1.
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("idle_mode", {4'b0, mode}, 7'd0);
            check("idle_an", {3'b0, an}, {3'b0, (i < 5) ? 4'b1111 : an_of(1 + (i - 5) / 4)});
            check("idle_seg", seg, (i < 5) ? 7'b1111111 : 7'b1111110);
        end

        // Echo beats low-pass; full ECHO word over one scan.
        echo_en = 1'b1; lowpass_en = 1'b1;
        tick();
        check("echo_mode", {4'b0, mode}, 7'd1);
        tick();
        seen = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            tick();
            case (an)
                4'b0111: begin exp_seg = 7'b0110000; seen[3] = 1'b1; end
                4'b1011: begin exp_seg = 7'b0110001; seen[2] = 1'b1; end
                4'b1101: begin exp_seg = 7'b1001000; seen[1] = 1'b1; end
                default: begin exp_seg = 7'b0000001; seen[0] = 1'b1; end
            endcase
            check("echo_seg", seg, exp_seg);
        end
        check("echo_all_digits", {3'b0, seen}, 7'b0001111);

        // Plus pulse over low-pass: 20 cycles of PLUS, then LOWPASS.
        echo_en = 1'b0;
        tick(); tick();
        check("lp_mode", {4'b0, mode}, 7'd2);
        plus = 1'b1;
        tick();
        plus = 1'b0;
        check("plus_first", {4'b0, mode}, 7'd3);
        for (int k = 2; k <= 20; k++) begin
            tick();
            check("plus_hold", {4'b0, mode}, 7'd3);
            if (an == 4'b0111)      check("plus_d3", seg, 7'b1000001);
            else if (an == 4'b1011) check("plus_d2", seg, 7'b0011000);
            else                    check("plus_blank", seg, 7'b1111111);
        end
        tick();
        check("plus_expire", {4'b0, mode}, 7'd2);

        // Simultaneous edges: PLUS; later minus edge restarts a full hold.
        lowpass_en = 1'b0;
        tick(); tick();
        check("back_idle", {4'b0, mode}, 7'd0);
        plus = 1'b1; minus = 1'b1;
        tick();
        plus = 1'b0; minus = 1'b0;
        check("both_plus", {4'b0, mode}, 7'd3);
        for (int k = 2; k <= 10; k++) tick();
        check("both_still_plus", {4'b0, mode}, 7'd3);
        minus = 1'b1;
        tick();
        minus = 1'b0;
        check("minus_switch", {4'b0, mode}, 7'd4);
        for (int k = 12; k <= 30; k++) tick();
        check("minus_hold_end", {4'b0, mode}, 7'd4);
        tick();
        check("minus_expire", {4'b0, mode}, 7'd0);

        // Reset pulse mid-hold while the second digit is lit.
        plus = 1'b1;
        tick();
        plus = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick();
            if (an == 4'b1011) found = 1'b1;
        end
        check("midhold_an_found", {6'b0, found}, 7'd1);
        check("midhold_mode", {4'b0, mode}, 7'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_seg", seg, 7'b1111111);
        check("rst_mid_an", {3'b0, an}, 7'b0001111);
        check("rst_mid_mode", {4'b0, mode}, 7'd0);

        // Minus high across reset release: one edge only, then IDLE.
        minus = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 1 || k == 20) check("minus_level_hold", {4'b0, mode}, 7'd4);
            if (k == 21 || k == 100) check("minus_level_idle", {4'b0, mode}, 7'd0);
        end
        minus = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
